instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/if_id_reg.sv | 70 +++++++
 rtl/instruction_fetch.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipeline stages: fetch FSM state encoding, the
// default reset PC, the NOP word used for pipeline bubbles, and small PC
// helpers shared by any stage that computes fetch addresses.
// ---------------------------------------------------------------------------
package cpu_pkg;

  // FETCH: request outstanding on the instruction memory port.
  // HOLD : a returned word waits in the skid buffer while ID is stalled.
  // DROP : a redirect arrived while a request was outstanding; the old
  //        request must complete and its word is thrown away.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  // Instruction addresses are word aligned; low two bits are forced to zero.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Sequential next address, wrapping modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Holds the fetched instruction, its address+4 and
// a valid flag for the decode stage.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   hold              keep current contents (highest priority)
//   bubble            load a NOP with valid cleared
//   load              load instr_in / pc_plus4_in with valid set
//   instr_in          instruction word to load
//   pc_plus4_in       address+4 of that word
//   instruction       registered instruction to ID
//   pc_plus4          registered address+4 to ID
//   valid             register holds a real instruction
// ---------------------------------------------------------------------------
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        bubble,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instruction,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;

  // Priority is hold > bubble > load; with none asserted contents stay put.
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    if (!hold) begin
      if (bubble) begin
        instr_d    = NOP_WORD;
        pc_plus4_d = '0;
        valid_d    = 1'b0;
      end else if (load) begin
        instr_d    = instr_in;
        pc_plus4_d = pc_plus4_in;
        valid_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_WORD;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instruction = instr_q;
  assign pc_plus4    = pc_plus4_q;
  assign valid       = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Instruction fetch stage: PC register, single-outstanding-request memory
// interface, one-entry skid buffer for stalls, redirect handling, and the
// IF/ID pipeline register (if_id_reg).
//
// Ports:
//   Clk, Rst_n        clock, asynchronous active-low reset
//   Stall             hold IF/ID and PC (from hazard unit)
//   Flush             load a bubble into IF/ID
//   Redirect          taken branch/jump from ID
//   RedirectPC        redirect target (low two bits ignored)
//   ImemReq           fetch request to instruction memory
//   ImemAddr          fetch address
//   ImemRdy           memory returned a word this cycle
//   ImemData          returned word
//   Instruction       IF/ID instruction to decode
//   PcPlus4           IF/ID address+4 of that instruction
//   Valid             IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemRdy,
  input  logic [31:0] ImemData,
  output logic [31:0] Instruction,
  output logic [31:0] PcPlus4,
  output logic        Valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drop_addr_q, drop_addr_d;
  logic [31:0]  skid_instr_q, skid_instr_d;
  logic [31:0]  skid_pc_plus4_q, skid_pc_plus4_d;
  logic         skid_valid_q, skid_valid_d;
  logic         req_en_q, req_en_d;

  logic         imem_req;
  logic         word_accepted;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_target;

  logic         id_hold;
  logic         id_bubble;
  logic         id_load;
  logic [31:0]  id_instr;
  logic [31:0]  id_pc_plus4;

  // req_en_q keeps ImemReq low until the first clock edge after reset is
  // released, so a late ImemRdy left over from before reset is ignored.
  assign req_en_d = 1'b1;

  // ImemRdy only counts while a request is actually presented. In DROP the
  // address of the abandoned request is replayed until it completes.
  always_comb begin
    imem_req        = req_en_q && (state_q != HOLD);
    word_accepted   = imem_req && ImemRdy;
    pc_plus4        = next_pc(pc_q);
    redirect_target = align_pc(RedirectPC);
  end

  assign ImemReq  = imem_req;
  assign ImemAddr = (state_q == DROP) ? drop_addr_q : pc_q;

  // Next-state logic. Redirect owns the PC and skid buffer; Stall owns the
  // IF/ID register, so a stalled decode stage never sees a redirect bubble.
  // Whenever IF/ID is not stalled and nothing is loaded, it takes a bubble.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    drop_addr_d     = drop_addr_q;
    skid_instr_d    = skid_instr_q;
    skid_pc_plus4_d = skid_pc_plus4_q;
    skid_valid_d    = skid_valid_q;
    id_hold         = Stall;
    id_load         = 1'b0;
    id_instr        = ImemData;
    id_pc_plus4     = pc_plus4;

    case (state_q)
      FETCH: begin
        if (Redirect) begin
          pc_d         = redirect_target;
          skid_valid_d = 1'b0;
          // An unanswered request must still be drained before refetching.
          if (imem_req && !ImemRdy) begin
            state_d     = DROP;
            drop_addr_d = pc_q;
          end
        end else if (word_accepted) begin
          pc_d = pc_plus4;
          if (Stall) begin
            skid_instr_d    = ImemData;
            skid_pc_plus4_d = pc_plus4;
            skid_valid_d    = 1'b1;
            state_d         = HOLD;
          end else begin
            // A flushed word is lost; the PC still advances past it.
            id_load = !Flush;
          end
        end
      end

      HOLD: begin
        if (Redirect) begin
          pc_d         = redirect_target;
          skid_valid_d = 1'b0;
          state_d      = FETCH;
        end else if (!Stall) begin
          id_load      = skid_valid_q && !Flush;
          id_instr     = skid_instr_q;
          id_pc_plus4  = skid_pc_plus4_q;
          skid_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end

      DROP: begin
        if (Redirect) begin
          pc_d = redirect_target;
        end
        if (word_accepted) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d      = FETCH;
        skid_valid_d = 1'b0;
      end
    endcase

    id_bubble = !id_load;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q         <= FETCH;
      pc_q            <= RESET_PC;
      drop_addr_q     <= RESET_PC;
      skid_instr_q    <= NOP_WORD;
      skid_pc_plus4_q <= '0;
      skid_valid_q    <= 1'b0;
      req_en_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      drop_addr_q     <= drop_addr_d;
      skid_instr_q    <= skid_instr_d;
      skid_pc_plus4_q <= skid_pc_plus4_d;
      skid_valid_q    <= skid_valid_d;
      req_en_q        <= req_en_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .hold        (id_hold),
    .bubble      (id_bubble),
    .load        (id_load),
    .instr_in    (id_instr),
    .pc_plus4_in (id_pc_plus4),
    .instruction (Instruction),
    .pc_plus4    (PcPlus4),
    .valid       (Valid)
  );

endmodule
